// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC width and default return-stack depth.
// Imported by call_stack and its storage sub-module.
package cpu_pkg;

   localparam int PC_WIDTH  = 10;
   localparam int RAS_DEPTH = 8;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b10,
      OP_POP  = 2'b01,
      OP_SWAP = 2'b11
   } ras_op_e;

endpackage

// File: rtl/call_stack_mem.sv
// Return-stack storage: one synchronous write port, one async read port.
// Contents are not reset; the stack logic masks them while empty.
module call_stack_mem
   import cpu_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH,
   parameter int DEPTH = RAS_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack with occupancy and sticky error flags.
// Define CALL_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module call_stack
   import cpu_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH,
   parameter int DEPTH = RAS_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]    ptr, ptr_n, waddr, raddr;
   logic [CW-1:0]    count_n;
   logic [WIDTH-1:0] rdata;
   logic             we, ovf_ev, unf_ev;
   ras_op_e          op;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign raddr = ptr - 1'b1;
   assign top   = empty ? '0 : rdata;
   assign op    = ras_op_e'({push, pop});

   always_comb begin
      we      = 1'b0;
      waddr   = ptr;
      ptr_n   = ptr;
      count_n = count;
      ovf_ev  = 1'b0;
      unf_ev  = 1'b0;
      unique case (op)
         OP_SWAP: begin
            we = 1'b1;
            if (empty) begin
               ptr_n   = ptr + 1'b1;
               count_n = count + 1'b1;
               unf_ev  = 1'b1;
            end else begin
               waddr = raddr;
            end
         end
         OP_PUSH: begin
            if (!full) begin
               we      = 1'b1;
               ptr_n   = ptr + 1'b1;
               count_n = count + 1'b1;
            end else begin
`ifdef CALL_STACK_WRAP_EN
               // oldest entry sits at ptr once full; overwrite it
               we    = 1'b1;
               ptr_n = ptr + 1'b1;
`else
               ovf_ev = 1'b1;
`endif
            end
         end
         OP_POP: begin
            if (!empty) begin
               ptr_n   = ptr - 1'b1;
               count_n = count - 1'b1;
            end else begin
               unf_ev = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         ptr       <= ptr_n;
         count     <= count_n;
         overflow  <= ovf_ev | (overflow & ~clr_err);
         underflow <= unf_ev | (underflow & ~clr_err);
      end
   end

   call_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (push_data),
      .raddr (raddr),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack (WIDTH=10, DEPTH=8).
// Expected return addresses come from a software stack model.
module tb_call_stack;

   localparam int W = 10;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   logic [W-1:0] push_data = '0;
   logic         clr_err = 1'b0;
   logic [W-1:0] top;
   logic [3:0]   count;
   logic         full, empty, overflow, underflow;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] sb [$];
   logic [W-1:0] exp_v;

   call_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .clr_err   (clr_err),
      .top       (top),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   // drive one strobe across a rising edge; returns 1ns after the edge
   task automatic step(input logic pu, input logic po,
                       input logic [W-1:0] d, input logic ce);
      push = pu; pop = po; push_data = d; clr_err = ce;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
   endtask

   task automatic push_sb(input logic [W-1:0] v);
      step(1'b1, 1'b0, v, 1'b0);
      sb.push_back(v);
   endtask

   // pop one entry, checking top before the edge against the model
   task automatic pop_check(input string nm);
      pop = 1'b1;
      #1;
      exp_v = (sb.size() > 0) ? sb[$] : '0;
      checks++;
      if (top !== exp_v) begin
         errors++;
         $display("FAIL %s: top=%h expected %h", nm, top, exp_v);
      end
      if (sb.size() > 0) void'(sb.pop_back());
      @(posedge clk);
      #1;
      pop = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: %b expected 1", empty); end
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL rst_count: %0d expected 0", count); end
      checks++;
      if (top !== 10'h000) begin errors++; $display("FAIL rst_top: %h expected 000", top); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL rst_full: %b expected 0", full); end
      checks++;
      if ({overflow, underflow} !== 2'b00) begin
         errors++; $display("FAIL rst_flags: %b%b expected 00", overflow, underflow);
      end
   endtask

   task automatic test_push_pop();
      logic [W-1:0] vals [3];
      vals[0] = 10'h005; vals[1] = 10'h00A; vals[2] = 10'h0F3;
      foreach (vals[i]) push_sb(vals[i]);
      checks++;
      if (count !== 4'd3) begin errors++; $display("FAIL pp_count: %0d expected 3", count); end
      checks++;
      if (top !== 10'h0F3) begin errors++; $display("FAIL pp_top: %h expected 0f3", top); end
      repeat (3) pop_check("pp_pop");
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty: %b expected 1", empty); end
   endtask

   task automatic test_underflow();
      step(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set: %b expected 1", underflow); end
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL unf_count: %0d expected 0", count); end
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: %b expected 0", underflow); end
      // push+pop on empty: push happens, underflow raised
      step(1'b1, 1'b1, 10'h2C4, 1'b0);
      checks++;
      if ({count, top, underflow} !== {4'd1, 10'h2C4, 1'b1}) begin
         errors++;
         $display("FAIL swap_empty: count=%0d top=%h unf=%b expected 1 2c4 1",
                  count, top, underflow);
      end
      // clear coinciding with a new error: the error wins
      do_reset();
      step(1'b0, 1'b1, '0, 1'b1);
      checks++;
      if (underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_evt: %b expected 1", underflow); end
      do_reset();
   endtask

   task automatic test_full();
      for (int i = 0; i < D; i++) push_sb(10'h100 + W'(i));
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL full_flag: %b expected 1", full); end
      step(1'b1, 1'b0, 10'h1FF, 1'b0);
`ifdef CALL_STACK_WRAP_EN
      void'(sb.pop_front());
      sb.push_back(10'h1FF);
      checks++;
      if (top !== 10'h1FF) begin errors++; $display("FAIL wrap_top: %h expected 1ff", top); end
      checks++;
      if (count !== 4'd8) begin errors++; $display("FAIL wrap_count: %0d expected 8", count); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: %b expected 0", overflow); end
      repeat (D) pop_check("wrap_pop");
`else
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: %b expected 1", full); end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: %b expected 1", overflow); end
      checks++;
      if (top !== 10'h107) begin errors++; $display("FAIL ovf_top: %h expected 107", top); end
      repeat (D) pop_check("ovf_pop");
`endif
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL full_drain: %b expected 1", empty); end
      do_reset();
   endtask

   task automatic test_replace();
      push_sb(10'h010);
      push_sb(10'h020);
      step(1'b1, 1'b1, 10'h3AA, 1'b0);
      void'(sb.pop_back());
      sb.push_back(10'h3AA);
      checks++;
      if (count !== 4'd2) begin errors++; $display("FAIL rep_count: %0d expected 2", count); end
      checks++;
      if (top !== 10'h3AA) begin errors++; $display("FAIL rep_top: %h expected 3aa", top); end
      checks++;
      if ({overflow, underflow} !== 2'b00) begin
         errors++; $display("FAIL rep_flags: %b%b expected 00", overflow, underflow);
      end
      repeat (2) pop_check("rep_pop");
      // replace while full sets no flag
      for (int i = 0; i < D; i++) push_sb(10'h200 + W'(i));
      step(1'b1, 1'b1, 10'h055, 1'b0);
      checks++;
      if ({count, top, overflow} !== {4'd8, 10'h055, 1'b0}) begin
         errors++;
         $display("FAIL rep_full: count=%0d top=%h ovf=%b expected 8 055 0",
                  count, top, overflow);
      end
      do_reset();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) push_sb(10'h040 + W'(i));
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL arst_count: %0d expected 0", count); end
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: %b expected 1", empty); end
      #2;
      reset = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      push_sb(10'h011);
      checks++;
      if (top !== 10'h011) begin errors++; $display("FAIL arst_top: %h expected 011", top); end
      checks++;
      if (count !== 4'd1) begin errors++; $display("FAIL arst_cnt1: %0d expected 1", count); end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_underflow();
      test_full();
      test_replace();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the single-cycle CPU. It saves the return PC on a call (`push`) and delivers it on a return (`pop`). Width and depth are generic, and the block reports occupancy, full/empty status and sticky overflow/underflow errors. It sits beside the PC register: `push_data` is driven from the PC+1 adder and `top` feeds the next-PC mux.

## Interface
- `WIDTH`, default 10: entry width in bits, equal to the PC width.
- `DEPTH`, default 8: number of entries. Must be a power of two and at least 2.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `push` input, 1 bit: store `push_data` on the next rising edge.
- `pop` input, 1 bit: discard the top entry on the next rising edge.
- `push_data` input, `WIDTH` bits: return address to store.
- `clr_err` input, 1 bit: synchronous clear of `overflow` and `underflow`.
- `top` output, `WIDTH` bits: combinational view of the newest entry. Reads 0 when empty.
- `count` output, `$clog2(DEPTH+1)` bits: number of valid entries, 0..DEPTH.
- `full` output, 1 bit: `count == DEPTH`.
- `empty` output, 1 bit: `count == 0`.
- `overflow` output, 1 bit: sticky flag, push rejected because the stack was full.
- `underflow` output, 1 bit: sticky flag, pop requested while the stack was empty.

## Operation
- State:
  - `ptr`: write pointer, `$clog2(DEPTH)` bits, wraps modulo DEPTH.
  - `count`.
  - Two error flags.
  - Storage array `mem[0:DEPTH-1]`.
- `top = mem[ptr-1]` (modulo DEPTH) when `count != 0`, else 0.
- Push only, not full: `mem[ptr] <= push_data`; `ptr+1`; `count+1`.
- Pop only, not empty: `ptr-1`; `count-1`. The popped value is the `top` presented during the pop cycle. The CPU consumes it combinationally in the same cycle, like a return.
- Push and pop together, not empty: replace the top entry.
  - `mem[ptr-1] <= push_data`.
  - `ptr` and `count` unchanged.
  - No flags set, including when full.
- Push and pop together, empty: perform the push only and set `underflow`.
- Pop only, empty: no state change; set `underflow`.
- Push only, full: behaviour depends on configuration, see below.
- `clr_err` clears both flags. If an error event occurs in the same cycle, the new event wins and the flag is set.
- There are no other modes or states. The block is a pointer/counter datapath with no FSM.

## Timing
- Reset values:
  - `ptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0.
  - `overflow` = 0, `underflow` = 0.
  - `top` = 0.
  - `mem` is not reset. Its contents are unobservable while empty.
- Reset is asynchronous. Asserting it mid-sequence empties the stack immediately, without waiting for an edge.
- Write latency is 1 cycle: a pushed value appears on `top` in the cycle after the push edge.
- Pop latency is 0 for data: `top` is valid before the edge. After the edge, `top` shows the next-older entry.
- `count`, `full`, `empty` and the flags are registered or decoded from registers. They update on the same edge as the operation.
- No handshake. `push` and `pop` are single-cycle strobes and are honoured on every edge.

## Configuration
- `CALL_STACK_WRAP_EN` defined: a push while full overwrites the oldest entry.
  - `mem[ptr] <= push_data`; `ptr+1`.
  - `count` stays at DEPTH.
  - `overflow` is not set; the oldest return address is lost silently. This is intended for deep-recursion code that never returns that far.
- `CALL_STACK_WRAP_EN` undefined: a push while full is dropped.
  - No write; `ptr` and `count` unchanged.
  - `overflow` is set.

## Structure
- The shared package `cpu_pkg` holds `PC_WIDTH` (10) and the default `RAS_DEPTH` (8). The CPU top instantiates `call_stack` with these values.
- One natural sub-module is `call_stack_mem`: a DEPTH×WIDTH array with one synchronous write port and one asynchronous read port. The pointer, count and flag logic stays in `call_stack`.

## Test plan
All scenarios use WIDTH=10 and DEPTH=8.
- Reset, then idle → `empty` = 1, `count` = 0, `top` = 0, both flags 0.
- Push 0x005, 0x00A, 0x0F3 → `count` = 3 and `top` = 0x0F3. Then pop three times → `top` reads 0x0F3, 0x00A, 0x005 in those cycles, ending with `empty` = 1.
- Pop while empty → `underflow` = 1, `count` stays 0. Then `clr_err` → `underflow` = 0.
- Push 8 values 0x100..0x107, then push 0x1FF.
  - Without the macro: `full` = 1, `overflow` = 1, `top` = 0x107.
  - With the macro: `top` = 0x1FF, `count` = 8, `overflow` = 0, and 8 pops return 0x1FF, then 0x107 down to 0x101.
- With `count` = 2 and `top` = 0x020, push 0x3AA together with pop → `count` = 2, `top` = 0x3AA, no flags.
- Push 4 values, then assert `reset` asynchronously between edges → `count` = 0 and `empty` = 1 immediately. A subsequent push of 0x011 gives `top` = 0x011 and `count` = 1.
